// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder: ext(x) + ext(y) + cin, split into BLK-bit
// look-ahead blocks with one register stage per block and a valid/ready output.
module pipelined_cla_adder #(
  parameter int XW  = 8,
  parameter int YW  = 4,
  parameter int BLK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          signed_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW:0]   s
);
  localparam int SW = XW + 1;
  localparam int NB = (SW + BLK - 1) / BLK;
  localparam int PW = NB * BLK;

  // Flat sum-of-products carries: each carry is an OR of g/p/cin product terms.
  function automatic logic [BLK:0] cla_block(input logic [BLK-1:0] a,
                                             input logic [BLK-1:0] b,
                                             input logic           c0);
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           term;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = c0;
    for (int i = 0; i < BLK; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[BLK], p ^ c[BLK-1:0]};
  endfunction

  // sa_q[k]: sum bits of blocks 0..k below, still-unused X bits above.
  logic [NB-1:0][SW-1:0] sa_q, sa_d;
  logic [NB-1:0][SW-1:0] bb_q, bb_d;
  logic [NB-1:0]         c_q, c_d;
  logic [NB-1:0]         v_q, v_d;
  logic [SW-1:0]         x_ext_s;
  logic [SW-1:0]         y_ext_s;
  logic                  advance_s;
  logic                  unused_tail_s;

  assign x_ext_s = {signed_mode & x[XW-1], x};
  assign y_ext_s = {{(SW-YW){signed_mode & y[YW-1]}}, y};

  assign advance_s = ~v_q[NB-1] | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = v_q[NB-1];
  assign s         = sa_q[NB-1];

  for (genvar k = 0; k < NB; k++) begin : g_stage
    logic [SW-1:0] a_in_s;
    logic [SW-1:0] b_in_s;
    logic          c_in_s;
    logic [PW-1:0] a_pad_s;
    logic [PW-1:0] b_pad_s;
    logic [PW-1:0] nxt_pad_s;
    logic [BLK:0]  res_s;
    logic          unused_pad_s;

    if (k == 0) begin : g_first
      assign a_in_s = x_ext_s;
      assign b_in_s = y_ext_s;
      assign c_in_s = cin;
    end else begin : g_next
      assign a_in_s = sa_q[k-1];
      assign b_in_s = bb_q[k-1];
      assign c_in_s = c_q[k-1];
    end

    // Add block k and splice its sum bits over the consumed X bits.
    always_comb begin
      a_pad_s   = PW'(a_in_s);
      b_pad_s   = PW'(b_in_s);
      res_s     = cla_block(a_pad_s[k*BLK +: BLK], b_pad_s[k*BLK +: BLK], c_in_s);
      nxt_pad_s = a_pad_s;
      nxt_pad_s[k*BLK +: BLK] = res_s[BLK-1:0];
    end

    assign sa_d[k] = nxt_pad_s[SW-1:0];
    assign bb_d[k] = b_in_s;
    assign c_d[k]  = res_s[BLK];
    assign unused_pad_s = ^{nxt_pad_s, b_pad_s};
  end

  // The final block's carry and the spent Y bits are never consumed.
  assign unused_tail_s = ^{bb_q, c_q[NB-1]};

  // Valid bits: flush on clear, shift with bubbles on advance, else hold.
  always_comb begin
    v_d = v_q;
    if (clear) begin
      v_d = '0;
    end else if (advance_s) begin
      v_d[0] = in_valid;
      for (int k = 1; k < NB; k++) v_d[k] = v_q[k-1];
    end else begin
      v_d = v_q;
    end
  end

  // Pipeline registers; data only moves when the whole pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      sa_q <= '0;
      bb_q <= '0;
      c_q  <= '0;
    end else begin
      v_q <= v_d;
      if (advance_s) begin
        sa_q <= sa_d;
        bb_q <= bb_d;
        c_q  <= c_d;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised and directed bench for pipelined_cla_adder: three parameter sets
// share one stimulus bus, each checked every cycle against a queue model.
module tb_pipelined_cla_adder;
  typedef struct {
    longint sum;
    int     age;
  } ent_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clear     = 1'b0;
  logic        sm        = 1'b0;
  logic        in_valid  = 1'b0;
  logic        cin       = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] xin       = 16'h0000;
  logic [15:0] yin       = 16'h0000;
  logic        ir0;
  logic        ov0;
  logic [8:0]  s0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_out0 = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Exact integer sum of the extended operands, reduced modulo 2^(xw+1).
  function automatic longint ref_sum(input longint xv, input longint yv, input bit c,
                                     input bit m, input int xw, input int yw);
    longint xe;
    longint ye;
    xe = xv;
    ye = yv;
    if (m && xv[xw-1]) xe = xv - (longint'(1) << xw);
    if (m && yv[yw-1]) ye = yv - (longint'(1) << yw);
    return (xe + ye + longint'(c)) & ((longint'(1) << (xw + 1)) - 1);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int XW  = (gi == 1) ? 16 : 8;
    localparam int YW  = (gi == 0) ? 4 : (gi == 1) ? 16 : 1;
    localparam int BLK = (gi == 0) ? 4 : (gi == 1) ? 5 : 16;
    localparam int SW  = XW + 1;
    localparam int NB  = (SW + BLK - 1) / BLK;

    logic          in_ready_s;
    logic          out_valid_s;
    logic [SW-1:0] s_s;
    ent_t          q[$];

    pipelined_cla_adder #(.XW(XW), .YW(YW), .BLK(BLK)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .signed_mode(sm),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .x(xin[XW-1:0]), .y(yin[YW-1:0]), .cin(cin),
      .out_valid(out_valid_s), .out_ready(out_ready), .s(s_s)
    );

    if (gi == 0) begin : g_tap
      assign ir0 = in_ready_s;
      assign ov0 = out_valid_s;
      assign s0  = s_s;
    end

    // Model: each accepted operation needs NB-1 further pipeline advances.
    initial begin : model
      bit ev;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete();
        end else begin
          ev = (q.size() > 0) && (q[0].age == NB - 1);
          if (clear) begin
            q.delete();
          end else if (!ev || out_ready) begin
            if (ev) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_valid)
              q.push_back('{sum: ref_sum(longint'(xin[XW-1:0]), longint'(yin[YW-1:0]),
                                          cin, sm, XW, YW), age: 0});
          end
        end
      end
    end

    initial begin : compare
      bit ev;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk($sformatf("u%0d reset out_valid", gi), longint'(out_valid_s), 64'd0);
          chk($sformatf("u%0d reset s", gi), longint'(s_s), 64'd0);
        end else begin
          ev = (q.size() > 0) && (q[0].age == NB - 1);
          chk($sformatf("u%0d in_ready", gi), longint'(in_ready_s), longint'(!ev || out_ready));
          chk($sformatf("u%0d out_valid", gi), longint'(out_valid_s), longint'(ev));
          if (ev && out_valid_s) chk($sformatf("u%0d s", gi), longint'(s_s), q[0].sum);
          if (gi == 0 && ev && out_ready) n_out0++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic put(input logic [15:0] xv, input logic [15:0] yv, input logic c, input logic m);
    xin = xv;
    yin = yv;
    cin = c;
    sm  = m;
    in_valid = 1'b1;
  endtask

  task automatic put_rand();
    put(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic accept();
    int guard;
    guard = 0;
    while (!ir0 && guard < 50) begin
      tick();
      guard++;
    end
    if (!ir0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept timeout: in_ready stuck at 0");
    end
    tick();
  endtask

  task automatic directed(input string nm, input logic [15:0] xv, input logic [15:0] yv,
                          input logic c, input logic m, input longint exp);
    out_ready = 1'b1;
    idle(4);
    put(xv, yv, c, m);
    accept();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk({nm, " early out_valid"}, longint'(ov0), 64'd0);
      tick();
    end
    chk({nm, " out_valid"}, longint'(ov0), 64'd1);
    chk({nm, " s"}, longint'(s0), exp);
  endtask

  initial begin : stim
    logic [15:0] xa;
    logic [15:0] ya;
    logic        ca;
    logic        ma;
    int          start;

    repeat (3) tick();
    chk("reset out_valid", longint'(ov0), 64'd0);
    chk("reset s", longint'(s0), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", longint'(ir0), 64'd1);

    chk("model unsigned carry", ref_sum(64'd255, 64'd15, 1'b0, 1'b0, 8, 4), 64'h10E);
    chk("model unsigned cin", ref_sum(64'd255, 64'd15, 1'b1, 1'b0, 8, 4), 64'h10F);
    chk("model signed neg", ref_sum(64'h80, 64'hF, 1'b0, 1'b1, 8, 4), 64'h17F);
    chk("model signed pos", ref_sum(64'h7F, 64'h7, 1'b1, 1'b1, 8, 4), 64'h087);
    chk("model wide signed", ref_sum(64'h8000, 64'hFFFF, 1'b1, 1'b1, 16, 16), 64'h18000);
    chk("model narrow y", ref_sum(64'h01, 64'h1, 1'b0, 1'b1, 8, 1), 64'h000);

    directed("unsigned carry", 16'h00FF, 16'h000F, 1'b0, 1'b0, 64'h10E);
    directed("unsigned cin", 16'h00FF, 16'h000F, 1'b1, 1'b0, 64'h10F);
    directed("signed neg", 16'h0080, 16'h000F, 1'b0, 1'b1, 64'h17F);
    directed("signed pos", 16'h007F, 16'h0007, 1'b1, 1'b1, 64'h087);

    idle(4);
    start = n_out0;
    for (int i = 0; i < 256; i++) begin
      put({8'($urandom), 8'(i)}, {12'($urandom), 4'(i)}, 1'(i & 1), 1'b0);
      chk("stream in_ready", longint'(ir0), 64'd1);
      tick();
    end
    idle(6);
    chk("stream count", longint'(n_out0 - start), 64'd256);

    // Backpressure with a full pipeline: the oldest result must sit still.
    xa = 16'($urandom);
    ya = 16'($urandom);
    ca = 1'($urandom);
    ma = 1'($urandom);
    put(xa, ya, ca, ma);
    tick();
    for (int i = 0; i < 2; i++) begin
      put_rand();
      tick();
    end
    put_rand();
    out_ready = 1'b0;
    #1;
    chk("stall in_ready", longint'(ir0), 64'd0);
    repeat (5) begin
      tick();
      chk("stall in_ready", longint'(ir0), 64'd0);
      chk("stall out_valid", longint'(ov0), 64'd1);
      chk("stall s", longint'(s0), ref_sum(longint'(xa[7:0]), longint'(ya[3:0]), ca, ma, 8, 4));
    end
    out_ready = 1'b1;
    tick();
    idle(8);

    // Flush with three operations in flight and one more offered.
    for (int i = 0; i < 3; i++) begin
      put_rand();
      tick();
    end
    put_rand();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clear out_valid", longint'(ov0), 64'd0);
    directed("after clear", 16'h1234, 16'h0009, 1'b1, 1'b0, 64'h03E);

    for (int i = 0; i < 600; i++) begin
      put_rand();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      tick();
    end
    clear = 1'b0;
    out_ready = 1'b1;
    idle(8);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) begin
      put_rand();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", longint'(ov0), 64'd0);
    chk("midreset s", longint'(s0), 64'd0);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midreset in_ready", longint'(ir0), 64'd1);
    directed("after reset", 16'h00F0, 16'h0008, 1'b0, 1'b1, 64'h1E8);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's fixed-width combinational carry-look-ahead adder.
- Adds an X operand (XW bits) and a narrower Y operand (YW bits) plus a carry-in.
- Supports unsigned and signed (sign-extending) operand modes.
- The sum is split into BLK-bit look-ahead blocks with one register stage per block, and results leave through a valid/ready handshake.
- Used wherever wide additions must close timing at the datapath clock, e.g. accumulators and address generators.

Parameters:
- XW, 8, width of operand X; must be >= YW.
- YW, 4, width of operand Y; must be >= 1.
- BLK, 4, carry-look-ahead block width in bits; must be >= 1.
- Derived: SW = XW+1 (sum width).
- Derived: NB = ceil(SW/BLK) (number of blocks, equal to pipeline depth).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all in-flight operations.
- signed_mode  input  1  1: X and Y are two's complement; 0: unsigned. Sampled with the operands.
- in_valid  input  1  operands present.
- in_ready  output  1  adder can accept operands this cycle.
- x  input  XW  operand X.
- y  input  YW  operand Y.
- cin  input  1  carry-in, weight 1.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  SW  sum.
- Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Arithmetic:
  - Both operands are extended to SW bits: zero-extended when signed_mode=0, sign-extended when signed_mode=1.
  - s = ext(x) + ext(y) + cin, modulo 2^SW. The result is exact in both modes, so no overflow is possible.
  - Unsigned: s[XW] is the carry-out.
  - Signed: s is the SW-bit two's-complement sum.
- Block structure:
  - Block k covers sum bits [k*BLK .. min((k+1)*BLK, SW)-1].
  - Per bit: generate g = a&b, propagate p = a^b.
  - Within a block, carries use full look-ahead (sum-of-products of g/p/carry-in), never ripple.
  - The last block may be narrower than BLK.
- Pipeline:
  - Stage k (k = 0..NB-1) registers:
    - the sum bits of blocks 0..k;
    - the carry out of block k;
    - the extended operand bits of blocks k+1..NB-1;
    - a valid bit.
  - Stage 0 computes block 0 from the accepted inputs and cin.
  - Stage k computes block k from stage k-1 registers.
  - s and out_valid are driven directly from stage NB-1 registers; no combinational path runs from inputs to outputs.
  - Latency: a transfer accepted on edge t produces out_valid=1 after edge t+NB-1 (NB=3 by default), when no stall occurs.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - Input transfer: in_valid & in_ready on a rising edge.
  - Output transfer: out_valid & out_ready.
  - All stages shift together when advance=1 and hold when advance=0.
  - A stage shifted without new input loads valid=0 (bubble). Bubbles are not collapsed.
  - While out_valid=1 and out_ready=0, s and out_valid are held stable.
  - Throughput: one result per cycle when out_ready stays high.
  - in_valid=1 while in_ready=0 is ignored; the source must hold its operands.
- clear:
  - Takes priority over advance: all stage valid bits go to 0 at the next edge, and any input offered that cycle is dropped.
  - Data registers may keep stale values.
  - in_ready is still computed as above during clear.
- Reset:
  - Asserting rst_n low clears all valid bits and data registers immediately, including mid-operation: out_valid=0, s=0.
  - in_ready=1 after reset.
  - In-flight operations are lost and no partial results appear.
- Degenerate parameters:
  - BLK >= SW gives NB=1, latency 1.
  - YW = XW: Y is extended by one bit only.

Test Plan:
- Unsigned carry (defaults): x=0xFF, y=0xF, cin=0, signed_mode=0, out_ready=1 -> s=0x10E with out_valid, 3 cycles after acceptance. Same operands with cin=1 -> s=0x10F.
- Signed: x=0x80 (-128), y=0xF (-1), cin=0, signed_mode=1 -> s=0x17F (-129). x=0x7F, y=0x7, cin=1 -> s=0x087.
- Streaming: back-to-back inputs x=i, y=i&0xF, cin=i&1 for i=0..255 with out_ready=1 -> 256 results in order, one per cycle, each matching the reference sum, in_ready constantly 1.
- Backpressure: out_ready=0 for 5 cycles while the pipeline is full -> in_ready=0, s/out_valid stable, no loss. On release, results drain in order with no duplicates.
- Flush and reset: clear=1 with 3 operations in flight -> out_valid=0 next cycle and the next accepted operand appears with normal latency. rst_n low mid-stream -> out_valid=0, s=0 immediately; after release, in_ready=1.
- Parameter sweep: XW=16, YW=16, BLK=5 (NB=4) and XW=8, YW=1, BLK=16 (NB=1) -> random signed/unsigned operands match the model with latency NB.
